// File: rtl/pe_input_commutator.sv
// Ping-pong reorder buffer feeding the radix-2x2 PE: serial samples in, quadruples k, k+N/4, k+N/2, k+3N/4 out.
// Define COMMUTATOR_BITREV_EN to bit-reverse the write index (natural-order input for a DIT stage).
module pe_input_commutator #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out0,
    output logic signed [WIDTH-1:0] out1,
    output logic signed [WIDTH-1:0] out2,
    output logic signed [WIDTH-1:0] out3,
    output logic                    out_valid,
    output logic                    frame_start,
    output logic [LOG2N-3:0]        tf_addr,
    input  logic [2*WIDTH-1:0]      tf_data,
    output logic [2*WIDTH-1:0]      tf,
    output logic                    bypass_n
);
    localparam int AW = LOG2N - 2;
    localparam int Q  = 1 << AW;
    localparam logic [LOG2N-1:0] W_LAST = '1;
    localparam logic [AW-1:0]    K_LAST = '1;

    logic signed [WIDTH-1:0] mem_q [2][4][Q];

    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic [AW-1:0]    k_q, k_d;
    logic [1:0]       full_q, full_d;

    logic                    vld_p0_q, first_p0_q;
    logic signed [WIDTH-1:0] data_p0_q [4];
    logic [AW-1:0]           tf_addr_q;

    logic                    vld_p1_q, frame_start_q, bypass_n_q;
    logic signed [WIDTH-1:0] out_q [4];
    logic [2*WIDTH-1:0]      tf_q;

    logic             wr_fire, adv, rd_issue;
    logic [LOG2N-1:0] widx;
    logic [1:0]       wsub;
    logic [AW-1:0]    waddr;

`ifdef COMMUTATOR_BITREV_EN
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction
    assign widx = bitrev(wcnt_q);
`else
    assign widx = wcnt_q;
`endif
    assign wsub  = widx[LOG2N-1 -: 2];
    assign waddr = widx[AW-1:0];

    assign in_ready = ~full_q[wbank_q];
    assign wr_fire  = in_valid & in_ready;
    // The whole read pipeline advances together; it only freezes on a presented, unaccepted quadruple.
    assign adv      = ~vld_p1_q | out_ready;
    assign rd_issue = adv & full_q[rbank_q];

    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        k_d     = k_q;
        full_d  = full_q;
        if (wr_fire) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == W_LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end
        if (rd_issue) begin
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire) mem_q[wbank_q][wsub][waddr] <= in_data;
    end

    // RD stage: the bank is read here so its full flag can clear without risk of overwrite during a stall
    always_ff @(posedge Clk) begin
        if (rd_issue) begin
            for (int i = 0; i < 4; i++) data_p0_q[i] <= mem_q[rbank_q][i][k_q];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wcnt_q        <= '0;
            wbank_q       <= 1'b0;
            rbank_q       <= 1'b0;
            k_q           <= '0;
            full_q        <= '0;
            vld_p0_q      <= 1'b0;
            first_p0_q    <= 1'b0;
            tf_addr_q     <= '0;
            vld_p1_q      <= 1'b0;
            frame_start_q <= 1'b0;
            bypass_n_q    <= 1'b0;
            tf_q          <= '0;
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            k_q     <= k_d;
            full_q  <= full_d;
            if (adv) begin
                vld_p0_q <= rd_issue;
                if (rd_issue) begin
                    first_p0_q <= (k_q == '0);
                    tf_addr_q  <= k_q;
                end
                // OUT stage: tf_data is the ROM word for tf_addr_q, i.e. the k held in the RD stage
                vld_p1_q      <= vld_p0_q;
                frame_start_q <= vld_p0_q & first_p0_q;
                if (vld_p0_q) begin
                    for (int i = 0; i < 4; i++) out_q[i] <= data_p0_q[i];
                    tf_q       <= tf_data;
                    bypass_n_q <= ~first_p0_q;
                end
            end
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign out_valid   = vld_p1_q;
    assign frame_start = frame_start_q;
    assign tf_addr     = tf_addr_q;
    assign tf          = tf_q;
    assign bypass_n    = bypass_n_q;

endmodule

// File: tb/tb_pe_input_commutator.sv
// Directed bench for pe_input_commutator at N=16; expectations come from a small index/ROM model.
module tb_pe_input_commutator;
    localparam int WIDTH = 16;
    localparam int LOG2N = 4;
    localparam int Q     = 4;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  out0, out1, out2, out3;
    logic              out_valid, frame_start, bypass_n;
    logic [LOG2N-3:0]  tf_addr;
    logic [2*WIDTH-1:0] tf_data, tf;

    typedef struct packed {
        logic [15:0] o0, o1, o2, o3;
        logic [31:0] tf;
        logic        bp;
        logic        fs;
    } quad_t;

    quad_t got_q[$];
    int checks = 0;
    int failures = 0;
    int drops = 0;

    pe_input_commutator #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .frame_start(frame_start),
        .tf_addr(tf_addr), .tf_data(tf_data), .tf(tf), .bypass_n(bypass_n)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rom(input logic [LOG2N-3:0] a);
        logic [15:0] re, im;
        re = 16'h7000 + 16'(a) * 16'h0101;
        im = 16'h0800 - 16'(a) * 16'h0033;
        return {re, im};
    endfunction

    assign tf_data = rom(tf_addr);

    function automatic int exp_s(input int base, input int k, input int j);
        int p = k + j * Q;
`ifdef COMMUTATOR_BITREV_EN
        int r = 0;
        for (int b = 0; b < LOG2N; b++) if (p[b]) r = r | (1 << (LOG2N - 1 - b));
        p = r;
`endif
        return base + p;
    endfunction

    function automatic quad_t exp_quad(input int base, input int k);
        quad_t e;
        e.o0 = 16'(exp_s(base, k, 0));
        e.o1 = 16'(exp_s(base, k, 1));
        e.o2 = 16'(exp_s(base, k, 2));
        e.o3 = 16'(exp_s(base, k, 3));
        e.tf = rom(2'(k));
        e.bp = (k != 0);
        e.fs = (k == 0);
        return e;
    endfunction

    function automatic quad_t cur_quad();
        quad_t c;
        c = {out0, out1, out2, out3, tf, bypass_n, frame_start};
        return c;
    endfunction

    always @(negedge Clk) begin
        if (Reset_n && out_valid && out_ready) got_q.push_back(cur_quad());
    end

    // Drive samples base..base+count-1; called at posedge+1, returns at posedge+1 after the last transfer.
    task automatic feed(input int base, input int count);
        int i = 0;
        int guard = 0;
        while (i < count && guard < 2000) begin
            in_valid = 1'b1;
            in_data  = 16'(base + i);
            @(negedge Clk);
            if (in_ready) i++;
            else drops++;
            @(posedge Clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (i != count) begin
            failures++;
            $display("FAIL feed_done accepted=%0d required=%0d", i, count);
        end
    endtask

    task automatic wait_quads(input int n);
        int g = 0;
        while (got_q.size() < n && g < 500) begin
            @(posedge Clk); #1;
            g++;
        end
    endtask

    task automatic test_reset;
        quad_t c;
        #2;
        c = cur_quad();
        checks++;
        if (c !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", c); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (tf_addr !== '0) begin failures++; $display("FAIL reset_tf_addr got=%h exp=0", tf_addr); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic;
        quad_t c;
        got_q.delete();
        feed(0, 16);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat_e got=%b exp=0", out_valid); end
        @(posedge Clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat_e1 got=%b exp=0", out_valid); end
        checks++;
        if (tf_addr !== 2'd0) begin failures++; $display("FAIL basic_tf_addr0 got=%0d exp=0", tf_addr); end
        @(posedge Clk); #1;
        c = cur_quad();
        checks++;
        if (out_valid !== 1'b1 || c !== exp_quad(0, 0)) begin
            failures++;
            $display("FAIL basic_first vld=%b got=%h exp=%h", out_valid, c, exp_quad(0, 0));
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++;
        if (tf_addr !== 2'd3) begin failures++; $display("FAIL basic_tf_addr3 got=%0d exp=3", tf_addr); end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_end got=%b exp=0", out_valid); end
        checks++;
        if (got_q.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < Q && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_quad(0, k)) begin
                failures++;
                $display("FAIL basic_q%0d got=%h exp=%h", k, got_q[k], exp_quad(0, k));
            end
        end
    endtask

    task automatic test_back_to_back;
        got_q.delete();
        drops = 0;
        feed(16, 48);
        wait_quads(12);
        repeat (4) begin @(posedge Clk); #1; end
        checks++;
        if (drops != 0) begin failures++; $display("FAIL b2b_in_ready_low got=%0d exp=0", drops); end
        checks++;
        if (got_q.size() != 12) begin failures++; $display("FAIL b2b_count got=%0d exp=12", got_q.size()); end
        for (int n = 0; n < 12 && n < got_q.size(); n++) begin
            checks++;
            if (got_q[n] !== exp_quad(16 + 16 * (n / Q), n % Q)) begin
                failures++;
                $display("FAIL b2b_q%0d got=%h exp=%h", n, got_q[n], exp_quad(16 + 16 * (n / Q), n % Q));
            end
        end
    endtask

    task automatic stall_ctl(output int holdbad, output int seen);
        int g = 0;
        holdbad = 0;
        while (!out_valid && g < 200) begin @(posedge Clk); #1; g++; end
        seen = out_valid;
        repeat (20) begin
            @(negedge Clk);
            if (out_valid !== 1'b1 || cur_quad() !== exp_quad(64, 0)) holdbad++;
        end
        @(posedge Clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_stall;
        int holdbad, seen;
        got_q.delete();
        drops = 0;
        out_ready = 1'b0;
        fork
            feed(64, 48);
            stall_ctl(holdbad, seen);
        join
        wait_quads(12);
        repeat (4) begin @(posedge Clk); #1; end
        checks++;
        if (seen != 1 || holdbad != 0) begin
            failures++;
            $display("FAIL stall_hold seen=%0d bad_cycles=%0d exp seen=1 bad_cycles=0", seen, holdbad);
        end
        checks++;
        if (drops == 0) begin failures++; $display("FAIL stall_in_ready_fell got=%0d low cycles exp>0", drops); end
        checks++;
        if (got_q.size() != 12) begin failures++; $display("FAIL stall_count got=%0d exp=12", got_q.size()); end
        for (int n = 0; n < 12 && n < got_q.size(); n++) begin
            checks++;
            if (got_q[n] !== exp_quad(64 + 16 * (n / Q), n % Q)) begin
                failures++;
                $display("FAIL stall_q%0d got=%h exp=%h", n, got_q[n], exp_quad(64 + 16 * (n / Q), n % Q));
            end
        end
    endtask

    task automatic test_reset_midop;
        quad_t c;
        got_q.delete();
        feed(200, 16);
        wait_quads(2);
        #2;
        Reset_n = 1'b0;
        #1;
        c = cur_quad();
        checks++;
        if (c !== '0 || out_valid !== 1'b0 || tf_addr !== '0) begin
            failures++;
            $display("FAIL rst_drain_outputs vld=%b tf_addr=%0d got=%h exp=0", out_valid, tf_addr, c);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_drain_in_ready got=%b exp=1", in_ready); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        feed(300, 8);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_fill vld=%b in_ready=%b exp vld=0 in_ready=1", out_valid, in_ready);
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        got_q.delete();
        repeat (30) begin @(posedge Clk); #1; end
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL rst_no_output got=%0d exp=0", got_q.size()); end
        feed(100, 16);
        wait_quads(4);
        checks++;
        if (got_q.size() != 4) begin failures++; $display("FAIL rst_fresh_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < Q && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_quad(100, k)) begin
                failures++;
                $display("FAIL rst_fresh_q%0d got=%h exp=%h", k, got_q[k], exp_quad(100, k));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_stall;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
